// File: rtl/d_mem.sv
// Data memory for the 12-bit microcontroller: DEPTH x DATA_W single-port RAM,
// synchronous write, combinational read. Define DMEM_WR_BYPASS_EN for write-first reads.
module d_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Enable,
  input  logic              Write_en,
  input  logic [ADDR_W-1:0] Address_port,
  input  logic [DATA_W-1:0] Input_data,
  output logic [DATA_W-1:0] Output_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_fire;
  logic [DATA_W-1:0] rd_data;

  // Enable gates both directions; Write_en alone never touches the array.
  assign wr_fire = Enable & Write_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[Address_port] <= Input_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!rst && Enable) begin
`ifdef DMEM_WR_BYPASS_EN
      if (Write_en) begin
        rd_data = Input_data;
      end else begin
        rd_data = mem_q[Address_port];
      end
`else
      // Read-old: a write in flight shows the word as it was before the edge.
      rd_data = mem_q[Address_port];
`endif
    end
  end

  assign Output_data = rd_data;

endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: directed vectors drive the RAM, expected reads
// are queued by the driver and checked by an independent monitor on the falling edge.
module tb_d_mem;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              Enable;
  logic              Write_en;
  logic [ADDR_W-1:0] Address_port;
  logic [DATA_W-1:0] Input_data;
  logic [DATA_W-1:0] Output_data;

  logic [DATA_W-1:0] exp_q[$];
  string             name_q[$];
  int                checks;
  int                errors;

  d_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .Enable       (Enable),
    .Write_en     (Write_en),
    .Address_port (Address_port),
    .Input_data   (Input_data),
    .Output_data  (Output_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after the rising edge and hold until the next one.
  task automatic drive(input logic r, input logic en, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    rst          = r;
    Enable       = en;
    Write_en     = we;
    Address_port = a;
    Input_data   = d;
  endtask

  task automatic expect_out(input logic [DATA_W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DATA_W-1:0] old_val);
    drive(1'b0, 1'b1, 1'b1, a, d);
`ifdef DMEM_WR_BYPASS_EN
    expect_out(d, $sformatf("wr_bypass_a%0h", a));
`else
    expect_out(old_val, $sformatf("wr_readold_a%0h", a));
`endif
  endtask

  task automatic read_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    drive(1'b0, 1'b1, 1'b0, a, 8'h00);
    expect_out(e, $sformatf("rd_a%0h", a));
  endtask

  // monitor / scoreboard
  initial begin
    logic [DATA_W-1:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (Output_data !== e) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h at %0t", nm, Output_data, e, $time);
        end
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // stimulus
  initial begin
    logic [ADDR_W-1:0] wa [8];
    logic [DATA_W-1:0] wd [8];
    wa = '{4'h0, 4'h1, 4'h5, 4'h8, 4'hA, 4'hF, 4'hB, 4'h9};
    wd = '{8'hAB, 8'h90, 8'hFF, 8'h12, 8'h34, 8'h75, 8'h64, 8'hFE};
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    Enable       = 1'b1;
    Write_en     = 1'b0;
    Address_port = '0;
    Input_data   = '0;

    // 1. reset, then a mid-cycle reset pulse, then every address reads 00
    drive(1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
    expect_out(8'h00, "reset_initial");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'h7, 8'h00);
    expect_out(8'h00, "reset_pulse");
    for (int i = 0; i < 16; i++) read_word(ADDR_W'(i), 8'h00);

    // 2. write burst, then read-back
    for (int i = 0; i < 8; i++) write_word(wa[i], wd[i], 8'h00);
    read_word(4'hA, 8'h34);
    read_word(4'h2, 8'h00);
    read_word(4'hF, 8'h75);
    read_word(4'hC, 8'h00);
    read_word(4'h0, 8'hAB);
    read_word(4'h9, 8'hFE);

    // 3. Enable=0 blocks the write and forces the output low
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'h3, 8'h5A);
      expect_out(8'h00, "gated_out");
    end
    drive(1'b0, 1'b0, 1'b0, 4'hA, 8'h00);
    expect_out(8'h00, "disabled_read_a");
    read_word(4'h3, 8'h00);

    // 4. overwrite timing: old word before the edge, new word right after
    write_word(4'h0, 8'hAB, 8'hAB);
    write_word(4'h0, 8'h11, 8'hAB);
    read_word(4'h0, 8'h11);

    // 5. reset asserted between edges of a write burst
    write_word(4'h2, 8'h77, 8'h00);
    write_word(4'h3, 8'h88, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 4'h0, 8'h99);
    expect_out(8'h00, "reset_mid_write");
    drive(1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
    expect_out(8'h00, "post_reset_a0");
    foreach (wa[i]) read_word(wa[i], 8'h00);
    read_word(4'h2, 8'h00);
    read_word(4'h3, 8'h00);
    write_word(4'h4, 8'hC3, 8'h00);
    read_word(4'h4, 8'hC3);
    read_word(4'h5, 8'h00);

    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
